// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: owns the M-mode trap CSRs and the privilege level, and
// sequences exceptions, interrupts and mret through a flush/redirect handshake.
package riscv_pkg;
    localparam int RV_XLEN = 32;

    typedef enum logic [3:0] {
        INSTR_ADDR_MISALIGNED = 4'd0,
        INSTR_ACCESS_FAULT    = 4'd1,
        ILLEGAL_INSTR         = 4'd2,
        BREAKPOINT            = 4'd3,
        LD_ADDR_MISALIGNED    = 4'd4,
        LD_ACCESS_FAULT       = 4'd5,
        ST_ADDR_MISALIGNED    = 4'd6,
        ST_ACCESS_FAULT       = 4'd7,
        ECALL_U               = 4'd8,
        ECALL_M               = 4'd11
    } ex_cause_t;

    // Interrupt codes share the exception encodings; only the mcause MSB differs.
    localparam ex_cause_t IRQ_M_SOFT  = BREAKPOINT;
    localparam ex_cause_t IRQ_M_TIMER = ST_ACCESS_FAULT;
    localparam ex_cause_t IRQ_M_EXT   = ECALL_M;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_M = 2'b11
    } priv_lvl_t;
endpackage

module trap_ctrl
    import riscv_pkg::*;
#(
    parameter logic [RV_XLEN-1:0] MTVEC_RESET = 'h100
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmt_valid_i,
    output logic               cmt_ready_o,
    input  logic [RV_XLEN-1:0] cmt_pc_i,
    input  logic [RV_XLEN-1:0] cmt_npc_i,
    input  logic               cmt_ex_valid_i,
    input  ex_cause_t          cmt_ex_cause_i,
    input  logic [RV_XLEN-1:0] cmt_ex_tval_i,
    input  logic               cmt_mret_i,
    input  logic [2:0]         irq_i,
    output logic               flush_o,
    input  logic               flush_ack_i,
    output logic               redirect_valid_o,
    output logic [RV_XLEN-1:0] redirect_pc_o,
    input  logic               csr_we_i,
    input  logic [11:0]        csr_addr_i,
    input  logic [RV_XLEN-1:0] csr_wdata_i,
    output logic [RV_XLEN-1:0] csr_rdata_o,
    output priv_lvl_t          priv_lvl_o
);
    localparam int XLEN = RV_XLEN;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_REDIR} state_t;
    typedef enum logic [1:0] {EV_NONE, EV_TRAP, EV_MRET} ev_kind_t;

    state_t          state;
    priv_lvl_t       priv_q;
    logic            mstatus_mie;
    logic            mstatus_mpie;
    priv_lvl_t       mstatus_mpp;
    logic [2:0]      mie_q;       // {meie, mtie, msie}, same order as irq_i
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;

    ev_kind_t        ev_kind;
    logic            ev_irq;
    ex_cause_t       ev_cause;
    logic [XLEN-1:0] ev_tval;
    logic [XLEN-1:0] ev_epc;
    logic [XLEN-1:0] ev_target;
    logic [2:0]      irq_en;
    logic            take_event;

    assign irq_en     = irq_i & mie_q & {3{(priv_q == PRIV_U) | mstatus_mie}};
    assign take_event = cmt_valid_i & cmt_ready_o & (ev_kind != EV_NONE);
    assign priv_lvl_o = priv_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        ev_kind  = EV_NONE;
        ev_irq   = 1'b0;
        ev_cause = ILLEGAL_INSTR;
        ev_tval  = '0;
        ev_epc   = cmt_pc_i;
        if (cmt_ex_valid_i) begin
            ev_kind  = EV_TRAP;
            ev_cause = cmt_ex_cause_i;
            ev_tval  = cmt_ex_tval_i;
        end else if (cmt_mret_i && priv_q == PRIV_U) begin
            ev_kind = EV_TRAP;
        end else if (cmt_mret_i) begin
            ev_kind = EV_MRET;
        end else if (|irq_en) begin
            ev_kind  = EV_TRAP;
            ev_irq   = 1'b1;
            ev_epc   = cmt_npc_i;
            ev_cause = irq_en[2] ? IRQ_M_EXT : (irq_en[0] ? IRQ_M_SOFT : IRQ_M_TIMER);
        end
    end

    always_comb begin
        ev_target = {mtvec_q[XLEN-1:2], 2'b00};
        if (ev_kind == EV_MRET) begin
            ev_target = mepc_q;
        end else if (ev_irq && mtvec_q[1:0] == 2'b01) begin
            ev_target = {mtvec_q[XLEN-1:2], 2'b00} + XLEN'({ev_cause, 2'b00});
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= ST_IDLE;
            cmt_ready_o      <= 1'b1;
            flush_o          <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (take_event) begin
                    state         <= ST_FLUSH;
                    cmt_ready_o   <= 1'b0;
                    flush_o       <= 1'b1;
                    redirect_pc_o <= ev_target;
                end
                ST_FLUSH: if (flush_ack_i) begin
                    state            <= ST_REDIR;
                    flush_o          <= 1'b0;
                    redirect_valid_o <= 1'b1;
                end
                ST_REDIR: begin
                    state            <= ST_IDLE;
                    redirect_valid_o <= 1'b0;
                    cmt_ready_o      <= 1'b1;
                end
                default: begin
                    state            <= ST_IDLE;
                    cmt_ready_o      <= 1'b1;
                    flush_o          <= 1'b0;
                    redirect_valid_o <= 1'b0;
                end
            endcase
        end
    end

    // Trap and mret updates take precedence over a CSR write in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            priv_q       <= PRIV_M;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mstatus_mpp  <= PRIV_U;
            mie_q        <= '0;
            mtvec_q      <= MTVEC_RESET;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
        end else if (take_event) begin
            if (ev_kind == EV_MRET) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
                priv_q       <= mstatus_mpp;
                mstatus_mpp  <= PRIV_U;
            end else begin
                mepc_q       <= ev_epc & ~XLEN'(3);
                mcause_q     <= {ev_irq, {(XLEN-5){1'b0}}, ev_cause};
                mtval_q      <= ev_tval;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
                mstatus_mpp  <= priv_q;
                priv_q       <= PRIV_M;
            end
        end else if (csr_we_i) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mstatus_mie  <= csr_wdata_i[3];
                    mstatus_mpie <= csr_wdata_i[7];
                    if (csr_wdata_i[12:11] == 2'b00) mstatus_mpp <= PRIV_U;
                    else if (csr_wdata_i[12:11] == 2'b11) mstatus_mpp <= PRIV_M;
                end
                CSR_MIE:    mie_q    <= {csr_wdata_i[11], csr_wdata_i[7], csr_wdata_i[3]};
                CSR_MTVEC:  mtvec_q  <= {csr_wdata_i[XLEN-1:2],
                                         csr_wdata_i[1] ? mtvec_q[1:0] : csr_wdata_i[1:0]};
                CSR_MEPC:   mepc_q   <= csr_wdata_i & ~XLEN'(3);
                CSR_MCAUSE: mcause_q <= csr_wdata_i;
                CSR_MTVAL:  mtval_q  <= csr_wdata_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_i)
            CSR_MSTATUS: begin
                csr_rdata_o[3]     = mstatus_mie;
                csr_rdata_o[7]     = mstatus_mpie;
                csr_rdata_o[12:11] = mstatus_mpp;
            end
            CSR_MIE: begin
                csr_rdata_o[11] = mie_q[2];
                csr_rdata_o[7]  = mie_q[1];
                csr_rdata_o[3]  = mie_q[0];
            end
            CSR_MTVEC:  csr_rdata_o = mtvec_q;
            CSR_MEPC:   csr_rdata_o = mepc_q;
            CSR_MCAUSE: csr_rdata_o = mcause_q;
            CSR_MTVAL:  csr_rdata_o = mtval_q;
            CSR_MIP: begin
                csr_rdata_o[11] = irq_i[2];
                csr_rdata_o[7]  = irq_i[1];
                csr_rdata_o[3]  = irq_i[0];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: reset, exceptions, vectored interrupts, precedence,
// mret round trip, CSR WARL behaviour, stalls and reset during a flush.
module tb_trap_ctrl;
    import riscv_pkg::*;
    localparam int XLEN = RV_XLEN;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            cmt_valid_i;
    logic            cmt_ready_o;
    logic [XLEN-1:0] cmt_pc_i;
    logic [XLEN-1:0] cmt_npc_i;
    logic            cmt_ex_valid_i;
    ex_cause_t       cmt_ex_cause_i;
    logic [XLEN-1:0] cmt_ex_tval_i;
    logic            cmt_mret_i;
    logic [2:0]      irq_i;
    logic            flush_o;
    logic            flush_ack_i;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            csr_we_i;
    logic [11:0]     csr_addr_i;
    logic [XLEN-1:0] csr_wdata_i;
    logic [XLEN-1:0] csr_rdata_o;
    priv_lvl_t       priv_lvl_o;

    int checks = 0;
    int failures = 0;

    trap_ctrl #(.MTVEC_RESET(32'h100)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmt_valid_i(cmt_valid_i), .cmt_ready_o(cmt_ready_o),
        .cmt_pc_i(cmt_pc_i), .cmt_npc_i(cmt_npc_i),
        .cmt_ex_valid_i(cmt_ex_valid_i), .cmt_ex_cause_i(cmt_ex_cause_i),
        .cmt_ex_tval_i(cmt_ex_tval_i), .cmt_mret_i(cmt_mret_i),
        .irq_i(irq_i), .flush_o(flush_o), .flush_ack_i(flush_ack_i),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
        .csr_rdata_o(csr_rdata_o), .priv_lvl_o(priv_lvl_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [XLEN-1:0] d);
        csr_we_i = 1'b1; csr_addr_i = a; csr_wdata_i = d;
        tick();
        csr_we_i = 1'b0;
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [XLEN-1:0] d);
        csr_addr_i = a;
        tick();
        d = csr_rdata_o;
    endtask

    // Retires one instruction, acks the flush in cycle ack_cycle and reports what came back.
    task automatic retire(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] npc,
                          input logic ex, input ex_cause_t cause, input logic [XLEN-1:0] tval,
                          input logic mret, input int ack_cycle,
                          output logic flush1, output int rcyc,
                          output logic [XLEN-1:0] rpc, output logic ready_after);
        cmt_valid_i = 1'b1; cmt_pc_i = pc; cmt_npc_i = npc; cmt_ex_valid_i = ex;
        cmt_ex_cause_i = cause; cmt_ex_tval_i = tval; cmt_mret_i = mret;
        tick();
        cmt_valid_i = 1'b0; cmt_ex_valid_i = 1'b0; cmt_mret_i = 1'b0; csr_we_i = 1'b0;
        flush1 = flush_o; rcyc = -1; rpc = '0; ready_after = 1'b0;
        for (int cyc = 1; cyc < 40 && rcyc < 0; cyc++) begin
            if (redirect_valid_o) begin
                rcyc = cyc; rpc = redirect_pc_o;
            end else begin
                flush_ack_i = (cyc == ack_cycle);
                tick();
            end
        end
        flush_ack_i = 1'b0;
        if (rcyc >= 0) begin
            tick();
            ready_after = cmt_ready_o & ~redirect_valid_o;
        end
    endtask

    task automatic test_reset();
        logic [XLEN-1:0] d;
        rst_i = 1'b1; cmt_valid_i = 0; cmt_pc_i = '0; cmt_npc_i = '0; cmt_ex_valid_i = 0;
        cmt_ex_cause_i = INSTR_ADDR_MISALIGNED; cmt_ex_tval_i = '0; cmt_mret_i = 0;
        irq_i = '0; flush_ack_i = 0; csr_we_i = 0; csr_addr_i = '0; csr_wdata_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        tick();
        checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL rst_flush: got %b exp 0", flush_o); end
        checks++; if (redirect_valid_o !== 1'b0) begin failures++; $display("FAIL rst_redir_valid: got %b exp 0", redirect_valid_o); end
        checks++; if (redirect_pc_o !== '0) begin failures++; $display("FAIL rst_redir_pc: got %h exp 0", redirect_pc_o); end
        checks++; if (cmt_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b exp 1", cmt_ready_o); end
        checks++; if (priv_lvl_o !== PRIV_M) begin failures++; $display("FAIL rst_priv: got %b exp 11", priv_lvl_o); end
        csr_read(12'h305, d);
        checks++; if (d !== 32'h100) begin failures++; $display("FAIL rst_mtvec: got %h exp 100", d); end
        csr_read(12'h300, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_mstatus: got %h exp 0", d); end
        csr_read(12'h342, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_mcause: got %h exp 0", d); end
        csr_read(12'h341, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_mepc: got %h exp 0", d); end
    endtask

    task automatic test_illegal();
        logic f1, rdy; int rc; logic [XLEN-1:0] rpc, d;
        retire(32'h2000, 32'h2004, 1'b1, ILLEGAL_INSTR, 32'hdead, 1'b0, 2, f1, rc, rpc, rdy);
        checks++; if (f1 !== 1'b1) begin failures++; $display("FAIL ill_flush_c1: got %b exp 1", f1); end
        checks++; if (rc !== 3) begin failures++; $display("FAIL ill_redir_cycle: got %0d exp 3", rc); end
        checks++; if (rpc !== 32'h100) begin failures++; $display("FAIL ill_redir_pc: got %h exp 100", rpc); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL ill_ready_back: got %b exp 1", rdy); end
        csr_read(12'h342, d);
        checks++; if (d !== 32'h2) begin failures++; $display("FAIL ill_mcause: got %h exp 2", d); end
        csr_read(12'h341, d);
        checks++; if (d !== 32'h2000) begin failures++; $display("FAIL ill_mepc: got %h exp 2000", d); end
        csr_read(12'h343, d);
        checks++; if (d !== 32'hdead) begin failures++; $display("FAIL ill_mtval: got %h exp dead", d); end
        csr_read(12'h300, d);
        checks++; if (d !== 32'h1800) begin failures++; $display("FAIL ill_mstatus: got %h exp 1800", d); end
    endtask

    task automatic test_csr_warl();
        logic [XLEN-1:0] d;
        csr_write(12'h300, 32'h0800); csr_read(12'h300, d);
        checks++; if (d !== 32'h1800) begin failures++; $display("FAIL warl_mpp01: got %h exp 1800", d); end
        csr_write(12'h300, 32'h1000); csr_read(12'h300, d);
        checks++; if (d !== 32'h1800) begin failures++; $display("FAIL warl_mpp10: got %h exp 1800", d); end
        csr_write(12'h300, 32'h0088); csr_read(12'h300, d);
        checks++; if (d !== 32'h0088) begin failures++; $display("FAIL warl_mpp00: got %h exp 88", d); end
        csr_write(12'h300, 32'hffff_ffff); csr_read(12'h300, d);
        checks++; if (d !== 32'h1888) begin failures++; $display("FAIL warl_mstatus_all: got %h exp 1888", d); end
        csr_write(12'h300, 32'h0);
        csr_write(12'h305, 32'h203); csr_read(12'h305, d);
        checks++; if (d !== 32'h200) begin failures++; $display("FAIL warl_mtvec_m3: got %h exp 200", d); end
        csr_write(12'h305, 32'h301); csr_read(12'h305, d);
        checks++; if (d !== 32'h301) begin failures++; $display("FAIL warl_mtvec_m1: got %h exp 301", d); end
        csr_write(12'h305, 32'h402); csr_read(12'h305, d);
        checks++; if (d !== 32'h401) begin failures++; $display("FAIL warl_mtvec_m2: got %h exp 401", d); end
        csr_write(12'h305, 32'h200);
        csr_write(12'h304, 32'hffff_ffff); csr_read(12'h304, d);
        checks++; if (d !== 32'h888) begin failures++; $display("FAIL warl_mie: got %h exp 888", d); end
        csr_write(12'h304, 32'h0);
        csr_write(12'h341, 32'h4003); csr_read(12'h341, d);
        checks++; if (d !== 32'h4000) begin failures++; $display("FAIL warl_mepc: got %h exp 4000", d); end
        csr_write(12'h342, 32'hffff_ffff); csr_read(12'h342, d);
        checks++; if (d !== 32'hffff_ffff) begin failures++; $display("FAIL warl_mcause: got %h exp ffffffff", d); end
        csr_write(12'h344, 32'hfff); csr_read(12'h344, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL warl_mip_ro: got %h exp 0", d); end
        irq_i = 3'b101; csr_read(12'h344, d); irq_i = 3'b000;
        checks++; if (d !== 32'h808) begin failures++; $display("FAIL warl_mip_lines: got %h exp 808", d); end
        csr_write(12'h345, 32'h1234); csr_read(12'h345, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL warl_unlisted: got %h exp 0", d); end
    endtask

    task automatic test_vectored_irq();
        logic f1, rdy; int rc; logic [XLEN-1:0] rpc, d;
        csr_write(12'h305, 32'h8000_0001);
        csr_write(12'h304, 32'h80);
        csr_write(12'h300, 32'h8);
        irq_i = 3'b010;
        retire(32'h3000, 32'h3004, 1'b0, ILLEGAL_INSTR, 32'h0, 1'b0, 1, f1, rc, rpc, rdy);
        irq_i = 3'b000;
        checks++; if (rc !== 2) begin failures++; $display("FAIL virq_redir_cycle: got %0d exp 2", rc); end
        checks++; if (rpc !== 32'h8000_001c) begin failures++; $display("FAIL virq_redir_pc: got %h exp 8000001c", rpc); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL virq_ready_c3: got %b exp 1", rdy); end
        csr_read(12'h342, d);
        checks++; if (d !== 32'h8000_0007) begin failures++; $display("FAIL virq_mcause: got %h exp 80000007", d); end
        csr_read(12'h341, d);
        checks++; if (d !== 32'h3004) begin failures++; $display("FAIL virq_mepc: got %h exp 3004", d); end
        csr_read(12'h343, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL virq_mtval: got %h exp 0", d); end
        csr_read(12'h300, d);
        checks++; if (d !== 32'h1880) begin failures++; $display("FAIL virq_mstatus: got %h exp 1880", d); end
    endtask

    task automatic test_irq_masked();
        logic [XLEN-1:0] d;
        irq_i = 3'b010;
        cmt_valid_i = 1'b1; cmt_pc_i = 32'h3100; cmt_npc_i = 32'h3104;
        tick();
        cmt_valid_i = 1'b0;
        checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL mask_mie0_flush: got %b exp 0", flush_o); end
        irq_i = 3'b000;
        csr_write(12'h300, 32'h8);
        irq_i = 3'b010; tick(); tick(); irq_i = 3'b000;
        cmt_valid_i = 1'b1; cmt_pc_i = 32'h3200; cmt_npc_i = 32'h3204;
        tick();
        cmt_valid_i = 1'b0;
        checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL mask_pulse_lost: got %b exp 0", flush_o); end
        csr_read(12'h342, d);
        checks++; if (d !== 32'h8000_0007) begin failures++; $display("FAIL mask_mcause_kept: got %h exp 80000007", d); end
        csr_write(12'h305, 32'h200);
    endtask

    task automatic test_precedence();
        logic f1, rdy; int rc; logic [XLEN-1:0] rpc, d;
        csr_write(12'h304, 32'h880);
        irq_i = 3'b110;
        retire(32'h5000, 32'h5004, 1'b1, LD_ACCESS_FAULT, 32'h5555, 1'b0, 1, f1, rc, rpc, rdy);
        checks++; if (rpc !== 32'h200) begin failures++; $display("FAIL prec_ex_pc: got %h exp 200", rpc); end
        csr_read(12'h342, d);
        checks++; if (d !== 32'h5) begin failures++; $display("FAIL prec_ex_mcause: got %h exp 5", d); end
        csr_read(12'h341, d);
        checks++; if (d !== 32'h5000) begin failures++; $display("FAIL prec_ex_mepc: got %h exp 5000", d); end
        csr_write(12'h300, 32'h1808);
        retire(32'h5010, 32'h5014, 1'b0, ILLEGAL_INSTR, 32'h0, 1'b0, 1, f1, rc, rpc, rdy);
        checks++; if (rpc !== 32'h200) begin failures++; $display("FAIL prec_irq_pc: got %h exp 200", rpc); end
        csr_read(12'h342, d);
        checks++; if (d !== 32'h8000_000b) begin failures++; $display("FAIL prec_mei_mcause: got %h exp 8000000b", d); end
        csr_read(12'h341, d);
        checks++; if (d !== 32'h5014) begin failures++; $display("FAIL prec_mei_mepc: got %h exp 5014", d); end
        csr_write(12'h300, 32'h8);
        csr_write(12'h304, 32'h888);
        irq_i = 3'b011;
        retire(32'h5020, 32'h5024, 1'b0, ILLEGAL_INSTR, 32'h0, 1'b0, 1, f1, rc, rpc, rdy);
        irq_i = 3'b000;
        csr_read(12'h342, d);
        checks++; if (d !== 32'h8000_0003) begin failures++; $display("FAIL prec_msi_mcause: got %h exp 80000003", d); end
    endtask

    task automatic test_mret();
        logic f1, rdy; int rc; logic [XLEN-1:0] rpc, d;
        csr_write(12'h300, 32'h80);
        csr_write(12'h341, 32'h4000);
        retire(32'h6000, 32'h6004, 1'b0, ILLEGAL_INSTR, 32'h0, 1'b1, 1, f1, rc, rpc, rdy);
        checks++; if (rpc !== 32'h4000) begin failures++; $display("FAIL mret_pc: got %h exp 4000", rpc); end
        checks++; if (priv_lvl_o !== PRIV_U) begin failures++; $display("FAIL mret_priv: got %b exp 00", priv_lvl_o); end
        csr_read(12'h300, d);
        checks++; if (d !== 32'h88) begin failures++; $display("FAIL mret_mstatus: got %h exp 88", d); end
        csr_read(12'h342, d);
        checks++; if (d !== 32'h8000_0003) begin failures++; $display("FAIL mret_mcause_kept: got %h exp 80000003", d); end
        retire(32'h4008, 32'h400c, 1'b0, ILLEGAL_INSTR, 32'hffff, 1'b1, 1, f1, rc, rpc, rdy);
        checks++; if (rpc !== 32'h200) begin failures++; $display("FAIL umret_pc: got %h exp 200", rpc); end
        checks++; if (priv_lvl_o !== PRIV_M) begin failures++; $display("FAIL umret_priv: got %b exp 11", priv_lvl_o); end
        csr_read(12'h342, d);
        checks++; if (d !== 32'h2) begin failures++; $display("FAIL umret_mcause: got %h exp 2", d); end
        csr_read(12'h343, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL umret_mtval: got %h exp 0", d); end
        csr_read(12'h341, d);
        checks++; if (d !== 32'h4008) begin failures++; $display("FAIL umret_mepc: got %h exp 4008", d); end
        csr_read(12'h300, d);
        checks++; if (d !== 32'h80) begin failures++; $display("FAIL umret_mstatus: got %h exp 80", d); end
    endtask

    task automatic test_conflict();
        logic f1, rdy; int rc; logic [XLEN-1:0] rpc, d;
        csr_we_i = 1'b1; csr_addr_i = 12'h343; csr_wdata_i = 32'h1234;
        retire(32'h7000, 32'h7004, 1'b1, BREAKPOINT, 32'h77, 1'b0, 1, f1, rc, rpc, rdy);
        csr_read(12'h343, d);
        checks++; if (d !== 32'h77) begin failures++; $display("FAIL conf_mtval: got %h exp 77", d); end
        csr_read(12'h342, d);
        checks++; if (d !== 32'h3) begin failures++; $display("FAIL conf_mcause: got %h exp 3", d); end
    endtask

    task automatic test_stall();
        logic [XLEN-1:0] d;
        cmt_valid_i = 1'b1; cmt_pc_i = 32'h7100; cmt_npc_i = 32'h7104;
        cmt_ex_valid_i = 1'b1; cmt_ex_cause_i = ECALL_M; cmt_ex_tval_i = 32'h71;
        tick();
        checks++; if (cmt_ready_o !== 1'b0) begin failures++; $display("FAIL stall_ready_low: got %b exp 0", cmt_ready_o); end
        cmt_pc_i = 32'h9000; cmt_ex_cause_i = ST_ACCESS_FAULT; cmt_ex_tval_i = 32'h99;
        repeat (5) tick();
        cmt_valid_i = 1'b0; cmt_ex_valid_i = 1'b0;
        checks++; if (flush_o !== 1'b1 || redirect_valid_o !== 1'b0) begin failures++; $display("FAIL stall_hold: got flush=%b redir=%b exp 1/0", flush_o, redirect_valid_o); end
        flush_ack_i = 1'b1; tick(); flush_ack_i = 1'b0;
        checks++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h200) begin failures++; $display("FAIL stall_redir: got v=%b pc=%h exp 1/200", redirect_valid_o, redirect_pc_o); end
        tick();
        checks++; if (redirect_valid_o !== 1'b0 || cmt_ready_o !== 1'b1) begin failures++; $display("FAIL stall_one_shot: got v=%b rdy=%b exp 0/1", redirect_valid_o, cmt_ready_o); end
        csr_read(12'h342, d);
        checks++; if (d !== 32'hb) begin failures++; $display("FAIL stall_mcause: got %h exp b", d); end
        csr_read(12'h343, d);
        checks++; if (d !== 32'h71) begin failures++; $display("FAIL stall_mtval: got %h exp 71", d); end
        flush_ack_i = 1'b1; tick(); tick(); flush_ack_i = 1'b0;
        checks++; if (flush_o !== 1'b0 || redirect_valid_o !== 1'b0 || cmt_ready_o !== 1'b1) begin failures++; $display("FAIL idle_ack_ignored: got f=%b v=%b r=%b exp 0/0/1", flush_o, redirect_valid_o, cmt_ready_o); end
    endtask

    task automatic test_reset_mid_flush();
        logic [XLEN-1:0] d; int seen;
        csr_write(12'h300, 32'h80);
        cmt_valid_i = 1'b1; cmt_mret_i = 1'b1; cmt_pc_i = 32'h7200; cmt_npc_i = 32'h7204;
        tick();
        cmt_valid_i = 1'b0; cmt_mret_i = 1'b0;
        checks++; if (flush_o !== 1'b1 || priv_lvl_o !== PRIV_U) begin failures++; $display("FAIL rmf_pre: got f=%b priv=%b exp 1/00", flush_o, priv_lvl_o); end
        #2 rst_i = 1'b1;
        #1;
        checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL rmf_flush_drop: got %b exp 0", flush_o); end
        checks++; if (cmt_ready_o !== 1'b1 || redirect_pc_o !== '0) begin failures++; $display("FAIL rmf_outputs: got r=%b pc=%h exp 1/0", cmt_ready_o, redirect_pc_o); end
        checks++; if (priv_lvl_o !== PRIV_M) begin failures++; $display("FAIL rmf_priv: got %b exp 11", priv_lvl_o); end
        flush_ack_i = 1'b1;
        tick();
        rst_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (redirect_valid_o) seen++;
        end
        flush_ack_i = 1'b0;
        checks++; if (seen !== 0) begin failures++; $display("FAIL rmf_no_redirect: got %0d exp 0", seen); end
        csr_read(12'h305, d);
        checks++; if (d !== 32'h100) begin failures++; $display("FAIL rmf_mtvec: got %h exp 100", d); end
        csr_read(12'h300, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rmf_mstatus: got %h exp 0", d); end
        csr_read(12'h343, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rmf_mtval: got %h exp 0", d); end
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_csr_warl();
        test_vectored_irq();
        test_irq_masked();
        test_precedence();
        test_mret();
        test_conflict();
        test_stall();
        test_reset_mid_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap controller sitting directly downstream of the commit stage: it consumes the `riscv_pkg` exception causes and interrupt encodings attached to retiring instructions. It owns the trap CSRs (mstatus subset, mie, mip, mtvec, mepc, mcause, mtval) and the current privilege level. It sequences every synchronous exception, interrupt and `mret` through a flush / redirect handshake with the pipeline front end. Only M and U privilege levels are supported; widths follow `RV_XLEN` (written XLEN below).

## Interface
Parameters:
- `MTVEC_RESET`, default `'h100`: reset value of mtvec, with mode bits = 0.

Ports:
- `clk_i`  in  1  clock; all state is updated on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `cmt_valid_i`  in  1  an instruction is retiring this cycle.
- `cmt_ready_o`  out  1  trap_ctrl accepts retirement; high only in IDLE.
- `cmt_pc_i`  in  XLEN  pc of the retiring instruction.
- `cmt_npc_i`  in  XLEN  pc of the next instruction.
- `cmt_ex_valid_i`  in  1  the retiring instruction raised a synchronous exception.
- `cmt_ex_cause_i`  in  `ex_cause_t`  exception cause.
- `cmt_ex_tval_i`  in  XLEN  trap value.
- `cmt_mret_i`  in  1  the retiring instruction is `mret`.
- `irq_i`  in  3  level interrupt lines {meip, mtip, msip}.
- `flush_o`  out  1  pipeline flush request.
- `flush_ack_i`  in  1  pipeline is empty.
- `redirect_valid_o`  out  1  one-cycle fetch redirect.
- `redirect_pc_o`  out  XLEN  redirect target.
- `csr_we_i`  in  1  CSR write strobe.
- `csr_addr_i`  in  12  CSR address.
- `csr_wdata_i`  in  XLEN  CSR write data.
- `csr_rdata_o`  out  XLEN  combinational read of `csr_addr_i`.
- `priv_lvl_o`  out  `priv_lvl_t`  current privilege level.

## Operation
- **Events.** An event is evaluated only on a handshake, i.e. `cmt_valid_i & cmt_ready_o`. Priority is:
  1. Synchronous exception (`cmt_ex_valid_i`).
  2. `mret` issued in U mode, which is converted to `ILLEGAL_INSTR` with tval 0.
  3. `mret`.
  4. Interrupt.
- **Interrupt enable and selection.**
  - An interrupt is enabled if its pending bit and its mie bit are both set, and either priv=U or mstatus.MIE=1.
  - Selection among enabled interrupts is MEI (11) > MSI (3) > MTI (7).
  - An interrupt is taken after the retiring instruction completes, so mepc = `cmt_npc_i`.
- **Trap update**, performed on the handshake edge:
  - mepc ← `cmt_pc_i` for an exception, `cmt_npc_i` for an interrupt; bits [1:0] are forced to 0.
  - mcause ← the cause; interrupts use the `ex_cause_t` encodings with the MSB set.
  - mtval ← tval for an exception, 0 for an interrupt.
  - MPIE ← MIE, MIE ← 0, MPP ← priv, priv ← M.
- **Trap target.** base = mtvec & ~3.
  - Exception, or mtvec mode 0: target = base.
  - Interrupt with mtvec mode 1: target = base + 4·code, where code is the low bits of the cause.
- **mret update:** MIE ← MPIE, MPIE ← 1, priv ← MPP, MPP ← U (2'b00). Target = mepc.
- **FSM states:** IDLE, FLUSH, REDIR.
  - IDLE → FLUSH on an accepted event. The target is latched into `redirect_pc_o` at that edge.
  - FLUSH: `flush_o`=1. On `flush_ack_i`=1 → REDIR.
  - REDIR: `redirect_valid_o`=1 for exactly one cycle, then → IDLE.
- **CSR map.** Unlisted addresses read 0 and ignore writes.
  - mstatus 0x300: MIE bit 3, MPIE bit 7, MPP [12:11]; all other bits read 0. MPP is WARL: written values 01 and 10 leave it unchanged.
  - mie 0x304: bits 3, 7, 11 are writable.
  - mtvec 0x305: mode is WARL; writing mode 2 or 3 keeps the old mode.
  - mepc 0x341: write data has [1:0] cleared.
  - mcause 0x342: full XLEN.
  - mtval 0x343: full XLEN.
  - mip 0x344: read-only, reflects `irq_i` at bits 11, 7, 3.
- **Conflicts.** A CSR write in the same cycle as an accepted event is dropped; trap/mret updates win.

## Timing
- **Reset values:**
  - State IDLE; priv = M.
  - mstatus, mie, mepc, mcause, mtval = 0; mtvec = `MTVEC_RESET`.
  - `flush_o`=0, `redirect_valid_o`=0, `redirect_pc_o`=0, `cmt_ready_o`=1.
- **Latency.** Event accepted in cycle 0 → `flush_o` high from cycle 1. If the ack arrives in cycle k, `redirect_valid_o` is high in cycle k+1 and `cmt_ready_o` is high again in cycle k+2. The minimum round trip is 3 cycles.
- **Stall behaviour.** `flush_ack_i` held low keeps the FSM in FLUSH indefinitely. An ack seen outside FLUSH is ignored.
- **Retirement outside IDLE.** While not in IDLE, `cmt_valid_i` is not accepted and does not update any state.
- **Interrupt sampling.** `irq_i` is sampled only at the handshake. A pulse that drops before any handshake is lost.
- **Reset mid-operation.** Asserting `rst_i` during FLUSH or REDIR returns the block to IDLE immediately (asynchronously); no redirect is issued.
- **CSR reads.** `csr_rdata_o` reflects a write from the following cycle.

## Test plan
- **Reset / defaults.** Reset, then read 0x305 → `'h100`; read 0x300 → 0; `priv_lvl_o`=M.
- **Illegal instruction.** Retire pc `'h2000` with `ILLEGAL_INSTR`, tval `'hdead`, ack after 2 cycles → redirect `'h100` in cycle 3; mcause=2, mepc=`'h2000`, mtval=`'hdead`, MPP=M, MIE=0.
- **Vectored timer interrupt.** mtvec=`'h8000_0001`, mie bit 7 set, MIE=1, mtip=1; retire with npc `'h3004` → redirect `'h8000_001C`; mcause MSB=1 and code 7; mepc=`'h3004`.
- **Exception/interrupt precedence.** meip and mtip both set, the same instruction faults with `LD_ACCESS_FAULT` → mcause=5. On the next retirement (after MIE is re-enabled): meip and mtip both set → cause 11 is taken.
- **mret round trip.** Write MPP=00, MPIE=1, mepc=`'h4000`; retire `mret` → redirect `'h4000`, priv=U, MIE=1. Then retire `mret` in U mode → mcause=2.
- **Reset mid-flush.** Assert `rst_i` while in FLUSH → `flush_o` drops immediately, no `redirect_valid_o`, and the reset values are restored.
